// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver.
//   uart_state_t      : frame FSM states (IDLE, START, DATA, PARITY, END)
//   DEF_* constants   : default serial timing and word size
//   cnt_w()           : counter width for a given count range (minimum 1 bit)
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        END    = 3'd4
    } uart_state_t;

    localparam int DEF_CLOCKS_PER_PULSE = 16;
    localparam int DEF_BITS_PER_WORD    = 8;

    // Width needed to count 0..range-1; never narrower than one bit.
    function automatic int cnt_w(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if
// Valid/ready payload stream into the UART transmitter.
//   s_valid : payload valid            (master -> slave)
//   s_data  : payload, W_IN bits       (master -> slave)
//   s_ready : slave can accept payload (slave -> master)
// -----------------------------------------------------------------------------
interface uart_tx_if #(
    parameter int W_IN = 16
) ();

    logic            s_valid;
    logic            s_ready;
    logic [W_IN-1:0] s_data;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );

endinterface

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Counts clock cycles within one serial bit period (0..CLOCKS_PER_PULSE-1) and
// flags the last cycle of the period.
//   clk     : clock, posedge
//   rst     : asynchronous active-high reset, clears the count
//   i_clear : synchronous clear to 0 (takes priority over counting)
//   i_en    : count enable
//   o_tc    : high on the last cycle of a bit period while enabled
// -----------------------------------------------------------------------------
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = DEF_CLOCKS_PER_PULSE
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tc
);

    localparam int            CW   = cnt_w(CLOCKS_PER_PULSE);
    localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_PULSE - 1);

    logic [CW-1:0] r_count;

    assign o_tc = i_en && (r_count == LAST);

    // Wraps to 0 on terminal count, holds while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear || o_tc) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Serialises a W_IN-bit payload as NUM_WORDS = W_IN/BITS_PER_WORD back-to-back
// UART frames, lowest word first. Each frame: start bit (0), BITS_PER_WORD data
// bits LSB first, even parity bit, one stop bit (1). Every bit lasts
// CLOCKS_PER_PULSE clocks.
//   clk  : clock, posedge
//   rst  : asynchronous active-high reset; abandons any frame in flight
//   s_if : payload stream (slave); s_ready is high only in IDLE
//   tx   : registered serial line, idles high
//   busy : high from the accepting edge until the last stop bit ends
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = DEF_CLOCKS_PER_PULSE,
    parameter int BITS_PER_WORD    = DEF_BITS_PER_WORD,
    parameter int W_IN             = 16
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  s_if,
    output logic      tx,
    output logic      busy
);

    localparam int NUM_WORDS = W_IN / BITS_PER_WORD;
    localparam int BW        = cnt_w(BITS_PER_WORD);
    localparam int WW        = cnt_w(NUM_WORDS);

    localparam logic [BW-1:0] BITS_LAST  = BW'(BITS_PER_WORD - 1);
    localparam logic [WW-1:0] WORDS_LAST = WW'(NUM_WORDS - 1);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_START  = START;
    localparam logic [2:0] ST_DATA   = DATA;
    localparam logic [2:0] ST_PARITY = PARITY;
    localparam logic [2:0] ST_END    = END;

    logic [2:0]      r_state;
    logic [W_IN-1:0] r_shift;
    logic            r_par;
    logic [BW-1:0]   r_bits;
    logic [WW-1:0]   r_words;
    logic            r_tx;

    logic [2:0]      w_state_nxt;
    logic [W_IN-1:0] w_shift_nxt;
    logic            w_par_nxt;
    logic [BW-1:0]   w_bits_nxt;
    logic [WW-1:0]   w_words_nxt;
    logic            w_tx_nxt;
    logic            w_handshake;
    logic            w_tc;
    logic            w_timer_en;

    assign w_handshake = s_if.s_valid && (r_state == ST_IDLE);
    assign w_timer_en  = (r_state != ST_IDLE);

    uart_bit_timer #(
        .CLOCKS_PER_PULSE (CLOCKS_PER_PULSE)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_handshake),
        .i_en    (w_timer_en),
        .o_tc    (w_tc)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_bits_nxt  = r_bits;
        w_words_nxt = r_words;

        case (r_state)
            ST_IDLE: begin
                if (s_if.s_valid) begin
                    w_state_nxt = ST_START;
                    w_shift_nxt = s_if.s_data;
                    w_words_nxt = '0;
                    w_bits_nxt  = '0;
                end
            end
            ST_START: begin
                w_par_nxt = 1'b0;
                if (w_tc) begin
                    w_state_nxt = ST_DATA;
                    w_bits_nxt  = '0;
                end
            end
            ST_DATA: begin
                // The shift register carries all remaining words, so after
                // one word has gone out the next word is already at bit 0.
                if (w_tc) begin
                    w_shift_nxt = r_shift >> 1;
                    w_par_nxt   = r_par ^ r_shift[0];
                    if (r_bits == BITS_LAST) begin
                        w_bits_nxt  = '0;
                        w_state_nxt = ST_PARITY;
                    end else begin
                        w_bits_nxt = r_bits + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_tc) begin
                    w_state_nxt = ST_END;
                end
            end
            ST_END: begin
                if (w_tc) begin
                    if (r_words == WORDS_LAST) begin
                        w_words_nxt = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_words_nxt = r_words + 1'b1;
                        w_state_nxt = ST_START;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // The line level is decoded from the next-state values so the registered
    // output changes on the same edge as the state it belongs to.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            ST_START:  w_tx_nxt = 1'b0;
            ST_DATA:   w_tx_nxt = w_shift_nxt[0];
            ST_PARITY: w_tx_nxt = w_par_nxt;
            default:   w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_bits  <= '0;
            r_words <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_bits  <= w_bits_nxt;
            r_words <= w_words_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    assign tx          = r_tx;
    assign busy        = (r_state != ST_IDLE);
    assign s_if.s_ready = (r_state == ST_IDLE);

endmodule
